// File: rtl/c432_irq_pkg.sv
// ----------------------------------------------------------------------------
// c432_irq_pkg
// Shared constants and types for the 27-channel C432 interrupt controller.
//   NCH      : request lines per bus
//   CHW      : width of a channel index (holds NCH-1)
//   NBUS     : number of request buses (A, B, C)
//   bus_e    : bus identifier, A has the highest priority
//   state_e  : controller FSM state
//   bus_onehot() : bus identifier to {C,B,A} one-hot flag vector
// ----------------------------------------------------------------------------
package c432_irq_pkg;

  localparam int NCH  = 9;
  localparam int CHW  = 4;
  localparam int NBUS = 3;

  typedef enum logic [1:0] {
    BUS_A = 2'd0,
    BUS_B = 2'd1,
    BUS_C = 2'd2
  } bus_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

  // Map a bus identifier onto the {irq_pc, irq_pb, irq_pa} flag vector.
  function automatic logic [2:0] bus_onehot(input bus_e bus);
    logic [2:0] oh;
    case (bus)
      BUS_A:   oh = 3'b001;
      BUS_B:   oh = 3'b010;
      BUS_C:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage : c432_irq_pkg

// File: rtl/c432_prio_enc.sv
// ----------------------------------------------------------------------------
// c432_prio_enc
// Combinational lowest-index priority encoder (bit 0 has highest priority).
//   req   in  N   request vector
//   valid out 1   at least one request bit is set
//   idx   out IW  index of the lowest set bit, 0 when none is set
// ----------------------------------------------------------------------------
module c432_prio_enc #(
  parameter int N  = 9,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx = req[i] ? IW'(i) : idx;
    end
  end

endmodule : c432_prio_enc

// File: rtl/c432_irq_ctrl.sv
// ----------------------------------------------------------------------------
// c432_irq_ctrl
// Sequential 27-channel interrupt controller. Requests from three 9-line
// buses are latched into a pending register, gated by a shared per-position
// enable, arbitrated (bus A > B > C, channel 0 first within a bus) and
// presented to the CPU on an irq/ack handshake. The acknowledged channel is
// held in service until end-of-interrupt; there is no nesting.
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_a/b/c   in   NCH request lines per bus
//   en          in   NCH per-position enable shared by all buses
//   ack         in   CPU acknowledge (honoured only while requesting)
//   eoi         in   CPU end-of-interrupt (honoured only while in service)
//   irq         out  interrupt request to the CPU
//   irq_pa/pb/pc out one-hot bus of the presented / served winner
//   irq_chan    out  channel index of the presented / served winner
//   in_service  out  an acknowledged interrupt awaits eoi
//   busy        out  controller is not idle
//   pending     out  pending register {C,B,A}, bit = bus*NCH + chan
// EDGE = 1 latches rising edges (cleared on ack); EDGE = 0 follows the
// request level every cycle.
// ----------------------------------------------------------------------------
module c432_irq_ctrl
  import c432_irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req_a,
  input  logic [NCH-1:0]    req_b,
  input  logic [NCH-1:0]    req_c,
  input  logic [NCH-1:0]    en,
  input  logic              ack,
  input  logic              eoi,
  output logic              irq,
  output logic              irq_pa,
  output logic              irq_pb,
  output logic              irq_pc,
  output logic [CHW-1:0]    irq_chan,
  output logic              in_service,
  output logic              busy,
  output logic [3*NCH-1:0]  pending
);

  // Request, pending and eligibility vectors, indexed [bus][chan].
  logic [NBUS-1:0][NCH-1:0] req_all_s;
  logic [NBUS-1:0][NCH-1:0] req_prev_q;
  logic [NBUS-1:0][NCH-1:0] pend_q;
  logic [NBUS-1:0][NCH-1:0] pend_d;
  logic [NBUS-1:0][NCH-1:0] pend_clr_s;
  logic [NBUS-1:0][NCH-1:0] elig_s;

  // Per-bus encoder results and the resolved overall winner.
  logic [NBUS-1:0]          valid_s;
  logic [NBUS-1:0][CHW-1:0] idx_s;
  logic                     any_elig_s;
  bus_e                     sel_bus_s;
  logic [CHW-1:0]           sel_chan_s;
  logic                     win_elig_s;

  // FSM and captured winner.
  state_e                   state_q;
  state_e                   state_d;
  bus_e                     win_bus_q;
  bus_e                     win_bus_d;
  logic [CHW-1:0]           win_chan_q;
  logic [CHW-1:0]           win_chan_d;

  // Output registers.
  logic                     irq_q;
  logic                     irq_d;
  logic [2:0]               irq_p_q;
  logic [2:0]               irq_p_d;
  logic [CHW-1:0]           irq_chan_q;
  logic [CHW-1:0]           irq_chan_d;
  logic                     in_service_q;
  logic                     in_service_d;
  logic                     busy_q;
  logic                     busy_d;

  assign req_all_s = {req_c, req_b, req_a};
  assign elig_s    = pend_q & {en, en, en};

  c432_prio_enc #(.N(NCH), .IW(CHW)) u_enc_a (
    .req   (elig_s[0]),
    .valid (valid_s[0]),
    .idx   (idx_s[0])
  );

  c432_prio_enc #(.N(NCH), .IW(CHW)) u_enc_b (
    .req   (elig_s[1]),
    .valid (valid_s[1]),
    .idx   (idx_s[1])
  );

  c432_prio_enc #(.N(NCH), .IW(CHW)) u_enc_c (
    .req   (elig_s[2]),
    .valid (valid_s[2]),
    .idx   (idx_s[2])
  );

  assign any_elig_s = |valid_s;
  // Eligibility of the captured winner, used to detect a withdrawn request.
  assign win_elig_s = elig_s[win_bus_q][win_chan_q];

  // Bus-level priority: A before B before C.
  always_comb begin
    sel_bus_s  = BUS_A;
    sel_chan_s = {CHW{1'b0}};
    if (valid_s[0]) begin
      sel_bus_s  = BUS_A;
      sel_chan_s = idx_s[0];
    end else if (valid_s[1]) begin
      sel_bus_s  = BUS_B;
      sel_chan_s = idx_s[1];
    end else if (valid_s[2]) begin
      sel_bus_s  = BUS_C;
      sel_chan_s = idx_s[2];
    end else begin
      sel_bus_s  = BUS_A;
      sel_chan_s = {CHW{1'b0}};
    end
  end

  // FSM next state, winner capture and pending-clear on acknowledge.
  always_comb begin
    state_d    = state_q;
    win_bus_d  = win_bus_q;
    win_chan_d = win_chan_q;
    pend_clr_s = '0;
    case (state_q)
      IDLE: begin
        if (any_elig_s) begin
          state_d    = REQ;
          win_bus_d  = sel_bus_s;
          win_chan_d = sel_chan_s;
        end else begin
          state_d    = IDLE;
        end
      end
      REQ: begin
        // ack wins over a simultaneous withdraw; eoi is meaningless here.
        if (ack) begin
          state_d = SERV;
          if (EDGE) begin
            pend_clr_s[win_bus_q][win_chan_q] = 1'b1;
          end else begin
            pend_clr_s = '0;
          end
        end else if (!win_elig_s) begin
          state_d    = IDLE;
          win_bus_d  = BUS_A;
          win_chan_d = {CHW{1'b0}};
        end else begin
          state_d    = REQ;
        end
      end
      SERV: begin
        if (eoi) begin
          state_d    = IDLE;
          win_bus_d  = BUS_A;
          win_chan_d = {CHW{1'b0}};
        end else begin
          state_d    = SERV;
        end
      end
      default: begin
        state_d    = IDLE;
        win_bus_d  = BUS_A;
        win_chan_d = {CHW{1'b0}};
      end
    endcase
  end

  // Pending next value; in edge mode a same-cycle set overrides the ack clear.
  always_comb begin
    if (EDGE) begin
      pend_d = (pend_q & ~pend_clr_s) | (req_all_s & ~req_prev_q);
    end else begin
      pend_d = req_all_s;
    end
  end

  // Output next values are decoded from the next state so they leave a flop.
  always_comb begin
    irq_d        = (state_d == REQ);
    in_service_d = (state_d == SERV);
    busy_d       = (state_d != IDLE);
    if (state_d != IDLE) begin
      irq_p_d    = bus_onehot(win_bus_d);
      irq_chan_d = win_chan_d;
    end else begin
      irq_p_d    = 3'b000;
      irq_chan_d = {CHW{1'b0}};
    end
  end

  // State and captured winner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_bus_q  <= BUS_A;
      win_chan_q <= {CHW{1'b0}};
    end else begin
      state_q    <= state_d;
      win_bus_q  <= win_bus_d;
      win_chan_q <= win_chan_d;
    end
  end

  // Request history and pending registers; zero history makes a request
  // already high at reset release count as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_q <= '0;
      pend_q     <= '0;
    end else begin
      req_prev_q <= req_all_s;
      pend_q     <= pend_d;
    end
  end

  // Registered CPU-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q        <= 1'b0;
      irq_p_q      <= 3'b000;
      irq_chan_q   <= {CHW{1'b0}};
      in_service_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      irq_q        <= irq_d;
      irq_p_q      <= irq_p_d;
      irq_chan_q   <= irq_chan_d;
      in_service_q <= in_service_d;
      busy_q       <= busy_d;
    end
  end

  assign irq        = irq_q;
  assign irq_pa     = irq_p_q[0];
  assign irq_pb     = irq_p_q[1];
  assign irq_pc     = irq_p_q[2];
  assign irq_chan   = irq_chan_q;
  assign in_service = in_service_q;
  assign busy       = busy_q;
  assign pending    = pend_q;

endmodule : c432_irq_ctrl

// File: tb/tb_c432_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_c432_irq_ctrl
// Self-checking bench for c432_irq_ctrl: one edge-mode and one level-mode
// instance. Expected winners are queued when requests are driven and popped
// when irq is observed. Inputs change and outputs are sampled on the falling
// clock edge.
// ----------------------------------------------------------------------------
module tb_c432_irq_ctrl;

  typedef struct packed {
    logic [1:0] bus;
    logic [3:0] chan;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic [8:0]  req_a, req_b, req_c, en;
  logic        ack, eoi;
  logic        irq, irq_pa, irq_pb, irq_pc, in_service, busy;
  logic [3:0]  irq_chan;
  logic [26:0] pending;

  logic [8:0]  req_a_l, req_b_l, req_c_l, en_l;
  logic        ack_l, eoi_l;
  logic        irq_l, irq_pa_l, irq_pb_l, irq_pc_l, in_service_l, busy_l;
  logic [3:0]  irq_chan_l;
  logic [26:0] pending_l;

  exp_t        sb[$];
  exp_t        sb_l[$];
  exp_t        e;
  logic [2:0]  exp_oh;
  int          total;
  int          bad;

  c432_irq_ctrl #(.EDGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .en(en),
    .ack(ack), .eoi(eoi),
    .irq(irq), .irq_pa(irq_pa), .irq_pb(irq_pb), .irq_pc(irq_pc),
    .irq_chan(irq_chan), .in_service(in_service), .busy(busy),
    .pending(pending)
  );

  c432_irq_ctrl #(.EDGE(1'b0)) dut_lvl (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a_l), .req_b(req_b_l), .req_c(req_c_l), .en(en_l),
    .ack(ack_l), .eoi(eoi_l),
    .irq(irq_l), .irq_pa(irq_pa_l), .irq_pb(irq_pb_l), .irq_pc(irq_pc_l),
    .irq_chan(irq_chan_l), .in_service(in_service_l), .busy(busy_l),
    .pending(pending_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 9'h000; req_b = 9'h000; req_c = 9'h000; en = 9'h000;
    ack = 1'b0; eoi = 1'b0;
    req_a_l = 9'h000; req_b_l = 9'h000; req_c_l = 9'h000; en_l = 9'h000;
    ack_l = 1'b0; eoi_l = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({irq, irq_pa, irq_pb, irq_pc, in_service, busy} !== 6'b0) begin
      bad++; $display("FAIL rst_flags: got %b want 000000", {irq, irq_pa, irq_pb, irq_pc, in_service, busy}); end
    total++; if (irq_chan !== 4'd0) begin bad++; $display("FAIL rst_chan: got %0d want 0", irq_chan); end
    total++; if (pending !== 27'd0) begin bad++; $display("FAIL rst_pend: got %h want 0", pending); end
    total++; if ({irq_l, busy_l, pending_l} !== 29'd0) begin
      bad++; $display("FAIL rst_lvl: got %h want 0", {irq_l, busy_l, pending_l}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    en = 9'h1FF;
    req_b[4] = 1'b1;
    sb.push_back('{bus: 2'd1, chan: 4'd4});
    @(negedge clk);
    req_b[4] = 1'b0;
    total++; if (pending[13] !== 1'b1) begin bad++; $display("FAIL basic_pend: got %b want 1", pending[13]); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_early: got %b want 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq: got %b want 1", irq); end
    e = sb.pop_front();
    exp_oh = 3'b001 << e.bus;
    total++; if ({irq_pc, irq_pb, irq_pa} !== exp_oh) begin
      bad++; $display("FAIL basic_bus: got %b want %b", {irq_pc, irq_pb, irq_pa}, exp_oh); end
    total++; if (irq_chan !== e.chan) begin bad++; $display("FAIL basic_chan: got %0d want %0d", irq_chan, e.chan); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++; if ({in_service, irq} !== 2'b10) begin
      bad++; $display("FAIL basic_serv: got %b want 10", {in_service, irq}); end
    total++; if (pending[13] !== 1'b0) begin bad++; $display("FAIL basic_pclr: got %b want 0", pending[13]); end
    total++; if ({irq_pb, irq_chan} !== 5'b1_0100) begin
      bad++; $display("FAIL basic_hold: got %b want 10100", {irq_pb, irq_chan}); end
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    total++; if ({busy, irq_pb, irq_chan} !== 6'b0) begin
      bad++; $display("FAIL basic_eoi: got %b want 000000", {busy, irq_pb, irq_chan}); end
  endtask

  task automatic test_priority();
    req_a[7] = 1'b1; req_b[0] = 1'b1; req_c[0] = 1'b1;
    sb.push_back('{bus: 2'd0, chan: 4'd7});
    sb.push_back('{bus: 2'd1, chan: 4'd0});
    sb.push_back('{bus: 2'd2, chan: 4'd0});
    @(negedge clk);
    req_a[7] = 1'b0; req_b[0] = 1'b0; req_c[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8 && irq !== 1'b1; i++) @(negedge clk);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_irq%0d: got %b want 1", k, irq); end
      e = sb.pop_front();
      exp_oh = 3'b001 << e.bus;
      total++; if ({irq_pc, irq_pb, irq_pa, irq_chan} !== {exp_oh, e.chan}) begin
        bad++; $display("FAIL prio_win%0d: got %b want %b", k, {irq_pc, irq_pb, irq_pa, irq_chan}, {exp_oh, e.chan}); end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      total++; if (in_service !== 1'b1) begin bad++; $display("FAIL prio_serv%0d: got %b want 1", k, in_service); end
      eoi = 1'b1;
      @(negedge clk);
      eoi = 1'b0;
      total++; if ({busy, irq} !== 2'b00) begin bad++; $display("FAIL prio_idle%0d: got %b want 00", k, {busy, irq}); end
      if (k < 2) begin
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_lat%0d: got %b want 1", k, irq); end
      end
    end
    total++; if (pending !== 27'd0) begin bad++; $display("FAIL prio_pend: got %h want 0", pending); end
  endtask

  task automatic test_enable();
    en = 9'h1F7;
    req_a[3] = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({irq, busy, pending[3]} !== 3'b001) begin
      bad++; $display("FAIL en_masked: got %b want 001", {irq, busy, pending[3]}); end
    en = 9'h1FF;
    sb.push_back('{bus: 2'd0, chan: 4'd3});
    @(negedge clk);
    e = sb.pop_front();
    total++; if ({irq, irq_pa, irq_chan} !== {2'b11, e.chan}) begin
      bad++; $display("FAIL en_irq: got %b want %b", {irq, irq_pa, irq_chan}, {2'b11, e.chan}); end
    en = 9'h1F7;
    @(negedge clk);
    total++; if ({irq, irq_pa, busy, pending[3]} !== 4'b0001) begin
      bad++; $display("FAIL en_withdraw: got %b want 0001", {irq, irq_pa, busy, pending[3]}); end
    en = 9'h1FF;
    sb.push_back('{bus: 2'd0, chan: 4'd3});
    @(negedge clk);
    e = sb.pop_front();
    total++; if ({irq, irq_chan} !== {1'b1, e.chan}) begin
      bad++; $display("FAIL en_reirq: got %b want %b", {irq, irq_chan}, {1'b1, e.chan}); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    req_a[3] = 1'b0;
    total++; if (pending[3] !== 1'b0) begin bad++; $display("FAIL en_pclr: got %b want 0", pending[3]); end
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
  endtask

  task automatic test_level();
    en_l = 9'h1FF;
    req_c_l[8] = 1'b1;
    sb_l.push_back('{bus: 2'd2, chan: 4'd8});
    @(negedge clk);
    total++; if ({irq_l, pending_l[26]} !== 2'b01) begin
      bad++; $display("FAIL lvl_pend: got %b want 01", {irq_l, pending_l[26]}); end
    @(negedge clk);
    e = sb_l.pop_front();
    total++; if ({irq_l, irq_pc_l, irq_chan_l} !== {2'b11, e.chan}) begin
      bad++; $display("FAIL lvl_irq: got %b want %b", {irq_l, irq_pc_l, irq_chan_l}, {2'b11, e.chan}); end
    ack_l = 1'b1;
    @(negedge clk);
    ack_l = 1'b0;
    total++; if ({in_service_l, pending_l[26]} !== 2'b11) begin
      bad++; $display("FAIL lvl_serv: got %b want 11", {in_service_l, pending_l[26]}); end
    eoi_l = 1'b1;
    @(negedge clk);
    eoi_l = 1'b0;
    total++; if (busy_l !== 1'b0) begin bad++; $display("FAIL lvl_eoi: got %b want 0", busy_l); end
    sb_l.push_back('{bus: 2'd2, chan: 4'd8});
    @(negedge clk);
    e = sb_l.pop_front();
    total++; if ({irq_l, irq_pc_l, irq_chan_l} !== {2'b11, e.chan}) begin
      bad++; $display("FAIL lvl_reirq: got %b want %b", {irq_l, irq_pc_l, irq_chan_l}, {2'b11, e.chan}); end
    req_c_l[8] = 1'b0;
    for (int i = 0; i < 4 && irq_l !== 1'b0; i++) @(negedge clk);
    total++; if ({irq_l, busy_l, irq_pc_l} !== 3'b000) begin
      bad++; $display("FAIL lvl_withdraw: got %b want 000", {irq_l, busy_l, irq_pc_l}); end
    total++; if (pending_l !== 27'd0) begin bad++; $display("FAIL lvl_pend0: got %h want 0", pending_l); end
  endtask

  task automatic test_stray();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++; if ({busy, in_service, irq} !== 3'b000) begin
      bad++; $display("FAIL stray_ack: got %b want 000", {busy, in_service, irq}); end
    req_b[2] = 1'b1;
    sb.push_back('{bus: 2'd1, chan: 4'd2});
    repeat (2) @(negedge clk);
    req_b[2] = 1'b0;
    e = sb.pop_front();
    total++; if ({irq, irq_pb, irq_chan} !== {2'b11, e.chan}) begin
      bad++; $display("FAIL stray_irq: got %b want %b", {irq, irq_pb, irq_chan}, {2'b11, e.chan}); end
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    total++; if ({irq, busy, in_service} !== 3'b110) begin
      bad++; $display("FAIL stray_eoi: got %b want 110", {irq, busy, in_service}); end
    ack = 1'b1; eoi = 1'b1;
    @(negedge clk);
    ack = 1'b0; eoi = 1'b0;
    total++; if ({irq, busy, in_service} !== 3'b011) begin
      bad++; $display("FAIL stray_both: got %b want 011", {irq, busy, in_service}); end
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_done: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    req_a[0] = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL mid_serv: got %b want 1", in_service); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({irq, irq_pa, in_service, busy, irq_chan, pending} !== 35'd0) begin
      bad++; $display("FAIL mid_async: got %h want 0", {irq, irq_pa, in_service, busy, irq_chan, pending}); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{bus: 2'd0, chan: 4'd0});
    @(negedge clk);
    total++; if ({irq, pending[0]} !== 2'b01) begin
      bad++; $display("FAIL mid_edge1: got %b want 01", {irq, pending[0]}); end
    @(negedge clk);
    e = sb.pop_front();
    total++; if ({irq, irq_pa, irq_chan} !== {2'b11, e.chan}) begin
      bad++; $display("FAIL mid_edge2: got %b want %b", {irq, irq_pa, irq_chan}, {2'b11, e.chan}); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; eoi = 1'b1;
    req_a[0] = 1'b0;
    @(negedge clk);
    eoi = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_priority();
    test_enable();
    test_level();
    test_stray();
    test_reset_mid();
    total++; if (sb.size() + sb_l.size() != 0) begin
      bad++; $display("FAIL sb_empty: got %0d want 0", sb.size() + sb_l.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_c432_irq_ctrl
